// File: rtl/calc_pkg.sv
// calc_pkg -- shared display-nibble constants and converter state encoding.
// Rev 1.0
`default_nettype none

package calc_pkg;

   localparam int          DIGITS    = 11;
   localparam logic [3:0]  BLANK     = 4'hF;
   localparam logic [3:0]  MINUS     = 4'hA;
   localparam logic [43:0] DISP_ZERO = 44'hFFFFFFFFFF0;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_FORMAT = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/dabble_digit.sv
// dabble_digit -- one BCD digit of the double-dabble "add 3 if >= 5" correction.
// Rev 1.0
`default_nettype none

module dabble_digit (
   input  logic [3:0] i_digit,
   output logic [3:0] o_digit
);

   assign o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;

endmodule

`default_nettype wire

// File: rtl/bcd_result_converter.sv
// bcd_result_converter -- signed binary to blanked, signed BCD display word (sequential double-dabble).
// Rev 1.0
`default_nettype none

module bcd_result_converter #(
   parameter int N      = 32,
   parameter int DIGITS = 11
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [N-1:0]          tcBinary_in,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   BCD_R,
   output logic                  neg_R
);

   import calc_pkg::*;

   // The top nibble is reserved for a sign; magnitude digits live below it.
   localparam int ACC_W  = 4 * (DIGITS - 1);
   localparam int ITER_W = $clog2(N + 1);

   state_t              r_state;
   logic                r_sign;
   logic [N-1:0]        r_mag;
   logic [ACC_W-1:0]    r_acc;
   logic [ITER_W-1:0]   r_iter;

   logic [ACC_W-1:0]    w_adj;
   logic [4*DIGITS-1:0] w_fmt;
   logic [3:0]          w_msd;
   logic                w_nonzero;

   genvar gi;
   generate
      for (gi = 0; gi < DIGITS - 1; gi++) begin : g_dabble
         dabble_digit u_dabble (
            .i_digit (r_acc[4*gi +: 4]),
            .o_digit (w_adj[4*gi +: 4])
         );
      end
   endgenerate

   assign w_nonzero = |r_acc;

   always_comb begin
      w_msd = 4'd0;
      for (int i = 0; i < DIGITS - 1; i++) begin
         if (r_acc[4*i +: 4] != 4'd0) begin
            w_msd = 4'(i);
         end
      end

      w_fmt = {DIGITS{BLANK}};
      for (int i = 0; i < DIGITS - 1; i++) begin
         if (4'(i) <= w_msd) begin
            w_fmt[4*i +: 4] = r_acc[4*i +: 4];
         end
      end

      // Minus sits directly above the leading digit; zero is never signed.
      if (r_sign && w_nonzero) begin
         for (int i = 1; i < DIGITS; i++) begin
            if (4'(i) == (w_msd + 4'd1)) begin
               w_fmt[4*i +: 4] = MINUS;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_sign  <= 1'b0;
         r_mag   <= '0;
         r_acc   <= '0;
         r_iter  <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         BCD_R   <= DISP_ZERO;
         neg_R   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_sign  <= tcBinary_in[N-1];
                  r_mag   <= tcBinary_in[N-1] ? ((~tcBinary_in) + N'(1)) : tcBinary_in;
                  r_acc   <= '0;
                  r_iter  <= '0;
                  busy    <= 1'b1;
                  r_state <= ST_SHIFT;
               end
            end

            ST_SHIFT: begin
               {r_acc, r_mag} <= {w_adj, r_mag} << 1;
               r_iter         <= r_iter + ITER_W'(1);
               if (r_iter == ITER_W'(N - 1)) begin
                  r_state <= ST_FORMAT;
               end
            end

            ST_FORMAT: begin
               BCD_R   <= w_fmt;
               neg_R   <= r_sign & w_nonzero;
               done    <= 1'b1;
               busy    <= 1'b0;
               r_state <= ST_IDLE;
            end

            default: begin
               busy    <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_bcd_result_converter.sv
// tb_bcd_result_converter -- randomized scoreboard bench for bcd_result_converter.
// Rev 1.0
`default_nettype none

module tb_bcd_result_converter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [31:0] tcBinary_in = 32'd0;
   logic        busy;
   logic        done;
   logic [43:0] BCD_R;
   logic        neg_R;

   bcd_result_converter #(
      .N      (32),
      .DIGITS (11)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .tcBinary_in (tcBinary_in),
      .busy        (busy),
      .done        (done),
      .BCD_R       (BCD_R),
      .neg_R       (neg_R)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [43:0] bcd;
      logic        neg;
      int          acc_edge;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          checks = 0;
   int          failures = 0;
   int          edge_cnt = 0;
   logic [43:0] last_bcd = 44'hFFFFFFFFFF0;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Decimal rendering of the signed value, built digit by digit.
   function automatic exp_t model(input logic [31:0] v, input int acc);
      exp_t   e;
      longint sv;
      longint m;
      int     pos;
      sv = longint'($signed(v));
      e.neg = (sv < 0);
      m = e.neg ? -sv : sv;
      e.bcd = '1;
      pos = 0;
      do begin
         e.bcd[4*pos +: 4] = 4'(m % 10);
         m = m / 10;
         pos++;
      end while (m != 0);
      if (e.neg) e.bcd[4*pos +: 4] = 4'hA;
      e.acc_edge = acc;
      return e;
   endfunction

   always @(negedge clk) begin
      if (done === 1'b1) begin
         check("busy_with_done", 64'(busy), 64'd0);
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done: got done=1 BCD_R=%h expected no pending conversion", BCD_R);
         end else begin
            mon_e = sb.pop_front();
            check("bcd_word", 64'(BCD_R), 64'(mon_e.bcd));
            check("neg_flag", 64'(neg_R), 64'(mon_e.neg));
            check("latency_edges", 64'(edge_cnt - mon_e.acc_edge), 64'd33);
            last_bcd = mon_e.bcd;
         end
      end
   end

   task automatic accept(input logic [31:0] v, output int acc);
      @(posedge clk);
      #1;
      start = 1'b1;
      tcBinary_in = v;
      @(posedge clk);
      #1;
      acc = edge_cnt;
      start = 1'b0;
      tcBinary_in = $urandom;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL done_timeout: got %0d pending expected 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic convert(input logic [31:0] v);
      int          acc;
      logic [43:0] prev;
      prev = last_bcd;
      accept(v, acc);
      sb.push_back(model(v, acc));
      repeat (4) @(posedge clk);
      #1;
      check("hold_during_shift", 64'(BCD_R), 64'(prev));
      check("busy_mid", 64'(busy), 64'd1);
      wait_drain();
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_done"}, 64'(done), 64'd0);
      check({tag, "_bcd"},  64'(BCD_R), 64'h0FFFFFFFFFF0);
      check({tag, "_neg"},  64'(neg_R), 64'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int          acc;
      logic [31:0] v;

      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      check_reset_state("reset");

      convert(32'd0);
      convert(32'd12345);
      convert(32'hFFFFFFF9);
      convert(32'h7FFFFFFF);
      convert(32'h80000000);
      convert(32'hFFFFFFFF);

      for (int i = 0; i < 24; i++) begin
         case (i % 4)
            0:       v = $urandom;
            1:       v = $urandom_range(0, 99999);
            2:       v = 32'(-int'($urandom_range(1, 99999)));
            default: v = 32'(-int'($urandom_range(1, 9)));
         endcase
         convert(v);
      end

      // start held high: second request lands on the done cycle
      @(posedge clk);
      #1;
      start = 1'b1;
      tcBinary_in = 32'd100;
      @(posedge clk);
      #1;
      acc = edge_cnt;
      sb.push_back(model(32'd100, acc));
      sb.push_back(model(32'd999, acc + 34));
      repeat (4) @(posedge clk);
      #1;
      tcBinary_in = 32'd999;
      repeat (35) @(posedge clk);
      #1;
      start = 1'b0;
      wait_drain();
      repeat (40) @(posedge clk);

      convert(32'hFFFFFFF9);
      accept(32'hFFFFFE0C, acc);
      repeat (9) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      check_reset_state("abort");
      last_bcd = 44'hFFFFFFFFFF0;
      repeat (40) @(posedge clk);
      convert(32'd42);

      repeat (5) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
